// File: rtl/pic_8259_pkg.sv
// ---------------------------------------------------------------------------
// pic_8259_pkg
// Shared constants and bit-vector helpers for the 8259A IRR/ISR priority
// block. All priority arithmetic is done in "rank space": the vector is
// rotated so that the highest-priority level lands on bit 0. Inside that
// space a lower bit index means a higher priority.
// ---------------------------------------------------------------------------
package pic_8259_pkg;

  localparam int NUM_IRQ = 8;
  localparam int PRIO_W  = 3;

  // Bit i of the result is vec[(i + n) mod NUM_IRQ].
  function automatic logic [NUM_IRQ-1:0] rotate_right(input logic [NUM_IRQ-1:0] vec,
                                                      input logic [PRIO_W-1:0]  n);
    return NUM_IRQ'({vec, vec} >> n);
  endfunction

  // Inverse of rotate_right: bit i of the result is vec[(i - n) mod NUM_IRQ].
  function automatic logic [NUM_IRQ-1:0] rotate_left(input logic [NUM_IRQ-1:0] vec,
                                                     input logic [PRIO_W-1:0]  n);
    return NUM_IRQ'(({vec, vec} << n) >> NUM_IRQ);
  endfunction

  // Isolates the least-significant set bit; zero in gives zero out.
  function automatic logic [NUM_IRQ-1:0] lowest_set_onehot(input logic [NUM_IRQ-1:0] vec);
    return vec & (~vec + NUM_IRQ'(1));
  endfunction

endpackage

// File: rtl/priority_resolver_8259.sv
// ---------------------------------------------------------------------------
// priority_resolver_8259
// Purely combinational rotating-priority picker. The highest-priority level
// is priority_rotate+1 (mod 8); priority_rotate itself is the lowest.
//
// Ports:
//   request          in  [7:0]  candidate bits
//   priority_rotate  in  [2:0]  lowest-priority level
//   highest          out [7:0]  one-hot highest-priority set bit, 0 if none
// ---------------------------------------------------------------------------
module priority_resolver_8259
  import pic_8259_pkg::*;
(
  input  logic [NUM_IRQ-1:0] request,
  input  logic [PRIO_W-1:0]  priority_rotate,
  output logic [NUM_IRQ-1:0] highest
);

  logic [PRIO_W-1:0] top_level;

  assign top_level = priority_rotate + PRIO_W'(1);

  // Rotate into rank space, pick rank 0-most bit, rotate back.
  assign highest = rotate_left(lowest_set_onehot(rotate_right(request, top_level)), top_level);

endmodule

// File: rtl/interrupt_request_priority_8259.sv
// ---------------------------------------------------------------------------
// interrupt_request_priority_8259
// Interrupt Request Register (IRR), In-Service Register (ISR) and rotating
// priority resolution feeding the 8259A control logic.
//
// Optional build macro: PIC_IRQ_SYNC_EN -- when defined, the IR pins pass
// through a 2-flop synchroniser before edge detection / IRR logic (adds two
// cycles of pin-to-IRR latency). When undefined, pins feed the logic directly.
//
// Ports:
//   clock                            in  system clock
//   reset                            in  synchronous active-high reset
//   interrupt_request_pin            in  [7:0] raw IR7..IR0
//   write_initial_command_word_1     in  ICW1 strobe, clears all state
//   level_or_edge_toriggered_config  in  1 = level, 0 = edge triggered
//   special_fully_nest_config        in  SFNM enable
//   freeze                           in  hold IRR during acknowledge
//   clear_interrupt_request          in  [7:0] one-hot IRR clear
//   interrupt_mask                   in  [7:0] IMR
//   interrupt_special_mask           in  [7:0] special-mask ISR override
//   priority_rotate                  in  [2:0] lowest-priority level
//   latch_in_service                 in  copy interrupt into ISR
//   end_of_interrupt                 in  [7:0] one-hot ISR clear
//   interrupt                        out [7:0] registered one-hot winner
//   highest_level_in_service         out [7:0] one-hot top ISR bit
//   interrupt_request_register       out [7:0] IRR read-back
//   in_service_register              out [7:0] ISR read-back
// ---------------------------------------------------------------------------
module interrupt_request_priority_8259 #(
  parameter int NUM_IRQ = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt_request_pin,
  input  logic               write_initial_command_word_1,
  input  logic               level_or_edge_toriggered_config,
  input  logic               special_fully_nest_config,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_interrupt_request,
  input  logic [NUM_IRQ-1:0] interrupt_mask,
  input  logic [NUM_IRQ-1:0] interrupt_special_mask,
  input  logic [PRIO_W-1:0]  priority_rotate,
  input  logic               latch_in_service,
  input  logic [NUM_IRQ-1:0] end_of_interrupt,
  output logic [NUM_IRQ-1:0] interrupt,
  output logic [NUM_IRQ-1:0] highest_level_in_service,
  output logic [NUM_IRQ-1:0] interrupt_request_register,
  output logic [NUM_IRQ-1:0] in_service_register
);

  import pic_8259_pkg::*;

  if (NUM_IRQ != 8 || PRIO_W != 3) begin : g_bad_param
    $error("interrupt_request_priority_8259 supports only NUM_IRQ=8, PRIO_W=3");
  end

  logic [NUM_IRQ-1:0] ir;
  logic [NUM_IRQ-1:0] prev_ir;
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] isr;
  logic [NUM_IRQ-1:0] isr_next;
  logic [NUM_IRQ-1:0] interrupt_next;
  logic [NUM_IRQ-1:0] request_highest;
  logic [NUM_IRQ-1:0] request_rank;
  logic [NUM_IRQ-1:0] block_rank;
  logic [PRIO_W-1:0]  top_level;

`ifdef PIC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1;
  logic [NUM_IRQ-1:0] sync_q2;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= interrupt_request_pin;
      sync_q2 <= sync_q1;
    end
  end

  assign ir = sync_q2;
`else
  assign ir = interrupt_request_pin;
`endif

  // IRR next state. Clear always applies, even while frozen, and beats set.
  // NOTE: the default assignment first guarantees no latch is inferred on
  // paths (freeze high) where the if-branches do not assign.
  always_comb begin
    irr_next = irr & ~clear_interrupt_request;
    if (!freeze) begin
      if (level_or_edge_toriggered_config) begin
        irr_next = ir & ~clear_interrupt_request;
      end else begin
        // Set on a rising edge, hold while the pin stays high, drop when low.
        irr_next = ir & (irr | ~prev_ir) & ~clear_interrupt_request;
      end
    end
  end

  priority_resolver_8259 u_request_resolver (
    .request         (irr & ~interrupt_mask),
    .priority_rotate (priority_rotate),
    .highest         (request_highest)
  );

  priority_resolver_8259 u_in_service_resolver (
    .request         (isr),
    .priority_rotate (priority_rotate),
    .highest         (highest_level_in_service)
  );

  // Compare the winning request and the blocking ISR level in rank space,
  // where a numerically smaller one-hot value is a higher priority.
  assign top_level    = priority_rotate + PRIO_W'(1);
  assign request_rank = rotate_right(request_highest, top_level);
  assign block_rank   = lowest_set_onehot(rotate_right(isr & ~interrupt_special_mask, top_level));

  always_comb begin
    interrupt_next = '0;
    if (request_highest != '0) begin
      if ((block_rank == '0) ||
          (request_rank < block_rank) ||
          (special_fully_nest_config && (request_rank == block_rank))) begin
        interrupt_next = request_highest;
      end
    end
  end

  // Latch is OR-ed in after the EOI clear, so it wins on the same bit.
  assign isr_next = (isr & ~end_of_interrupt) |
                    (latch_in_service ? interrupt : '0);

  always_ff @(posedge clock) begin
    if (reset || write_initial_command_word_1) begin
      prev_ir   <= '0;
      irr       <= '0;
      isr       <= '0;
      interrupt <= '0;
    end else begin
      prev_ir   <= ir;
      irr       <= irr_next;
      isr       <= isr_next;
      interrupt <= interrupt_next;
    end
  end

  assign interrupt_request_register = irr;
  assign in_service_register        = isr;

endmodule

// File: doc/interrupt_request_priority_8259.md
Name: interrupt_request_priority_8259

Overview:
- Upstream neighbour of the 8259A control logic. Holds the Interrupt Request Register (IRR) and In-Service Register (ISR) and resolves rotating priority.
- Produces the one-hot `interrupt` and `highest_level_in_service` vectors that the control logic consumes.
- Consumes the control logic's mask, EOI, rotate, freeze, latch and clear signals.
- Also exposes IRR/ISR to the read logic.

Parameters:
- NUM_IRQ, 8, number of request lines; only 8 is legal, and elaboration errors on any other value.
- PRIO_W, 3, width of the rotate field, equal to log2(NUM_IRQ).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- interrupt_request_pin  in  8  raw IR7..IR0 pins
- write_initial_command_word_1  in  1  ICW1 strobe; clears all state
- level_or_edge_toriggered_config  in  1  1=level, 0=edge
- special_fully_nest_config  in  1  special fully nested mode (SFNM) enable
- freeze  in  1  hold IRR during an acknowledge sequence
- clear_interrupt_request  in  8  one-hot IRR clear
- interrupt_mask  in  8  IMR
- interrupt_special_mask  in  8  special-mask ISR override
- priority_rotate  in  3  lowest-priority level
- latch_in_service  in  1  copy `interrupt` into ISR
- end_of_interrupt  in  8  one-hot ISR clear
- interrupt  out  8  registered one-hot winning request; 0 = none
- highest_level_in_service  out  8  one-hot highest-priority ISR bit
- interrupt_request_register  out  8  IRR for read-back
- in_service_register  out  8  ISR for read-back

Behaviour:
- Clock and reset: one clock (`clock`). `reset` is synchronous and active-high. On reset, all outputs and the internal edge-history register are 0.
- ICW1: `write_initial_command_word_1` high acts as a synchronous clear equal to reset, except that masks are external and are not affected.
- Edge history: `prev_ir` <= IR pins every cycle, including while `freeze` is high.
- IRR update (applies only when `freeze` is low; while frozen IRR holds):
  - Edge mode: a bit sets on a 0→1 transition of its pin. It clears when the pin is low or its `clear_interrupt_request` bit is high.
  - Level mode: bit = pin & ~clear bit.
  - `clear_interrupt_request` also applies during `freeze`. Clear has priority over set in the same cycle.
- Priority order: highest = `priority_rotate`+1 mod 8, then ascending with wrap. Lowest = `priority_rotate`. With rotate=7 the order is 0 (highest) .. 7 (lowest).
- Candidate requests: IRR & ~`interrupt_mask`.
- Blocking level: the highest-priority bit of ISR & ~`interrupt_special_mask`.
  - A candidate wins only if its priority is strictly higher than the blocking level.
  - In SFNM, a candidate at the equal level also wins.
  - With no blocking ISR bit, any candidate wins.
- `interrupt` is registered: one cycle of latency from IRR/mask/ISR/rotate changes. It is 0 when there is no winner.
- ISR update, in order within a cycle:
  - `isr_next` = (ISR & ~`end_of_interrupt`) | (`latch_in_service` ? `interrupt` : 0).
  - Latch therefore wins over EOI on the same bit.
- `highest_level_in_service` is combinational from the ISR register using the current rotate value. It is 0 when ISR = 0.
- `interrupt_request_register` / `in_service_register` are direct register copies.
- No state machine beyond the IRR/ISR/edge registers. All updates happen on the `clock` rising edge.

Optional Feature:
- PIC_IRQ_SYNC_EN defined: IR pins pass through a 2-flop synchroniser (reset to 0) before edge detection and IRR logic, which adds 2 cycles of pin-to-IRR latency.
- Undefined: pins feed the logic directly and IRR updates on the first edge after the pin changes.

Decomposition:
- Shared package `pic_8259_pkg`:
  - constants NUM_IRQ=8, PRIO_W=3;
  - functions `rotate_right(vec, n)`, `rotate_left(vec, n)`, `lowest_set_onehot(vec)`.
- One sub-module `priority_resolver_8259`, purely combinational: takes an 8-bit vector and `priority_rotate`, returns the one-hot highest-priority bit. Instantiated twice (requests, ISR).

Test Plan:
- Edge mode, rotate=7, mask=0x00: pulse IR2 0→1 → IRR=0x04 next cycle and `interrupt`=0x04 the cycle after. Drop IR2 → IRR=0x00.
- IRR=0x11, rotate=3 → `interrupt`=0x10, because IR4 outranks IR0 after rotation. With rotate=7 → `interrupt`=0x01.
- Nesting: ISR=0x04, IRR=0x0C → `interrupt`=0x00 with SFNM=0, and `interrupt`=0x04 with SFNM=1. IRR=0x0D → `interrupt`=0x01.
- Mask: IRR=0x03, mask=0x01 → `interrupt`=0x02. Set special_mask=0x04 with ISR=0x04 and IRR=0x08 → `interrupt`=0x08.
- ISR race: `interrupt`=0x08, `latch_in_service`=1 and `end_of_interrupt`=0x08 in the same cycle → ISR=0x08. Then EOI=0x08 alone → ISR=0x00 and `highest_level_in_service`=0x00.
- Freeze plus reset mid-operation:
  - `freeze`=1 with a new IR5 edge → IRR unchanged.
  - Assert `reset` with IRR=0xFF, ISR=0x10 → all outputs are 0 the next cycle.
  - Under PIC_IRQ_SYNC_EN, an IR1 edge reaches IRR 3 cycles after the pin change.
